// File: rtl/cp_pkg.sv
// ---------------------------------------------------------------------------
// cp_pkg
// Shared definitions for the charge-pump pulse sequencer and its helpers.
//   cp_state_t : sequencer phase encoding
//   CP_DIR_*   : command direction encoding (sink / source)
//   *_OFF      : idle (safe) level of each switch enable
// ---------------------------------------------------------------------------
package cp_pkg;

    typedef enum logic [2:0] {
        CP_IDLE      = 3'd0,
        CP_PRECHARGE = 3'd1,
        CP_DEAD      = 3'd2,
        CP_PULSE_HI  = 3'd3,
        CP_PULSE_LO  = 3'd4
    } cp_state_t;

    localparam logic CP_DIR_SNK = 1'b0;
    localparam logic CP_DIR_SRC = 1'b1;

    // src_n is active-low, so its safe level is high.
    localparam logic SRC_N_OFF  = 1'b1;
    localparam logic SNK_OFF    = 1'b0;

endpackage : cp_pkg

// File: rtl/cp_sync2.sv
// ---------------------------------------------------------------------------
// cp_sync2
// Two-flop synchronizer for an asynchronous single-bit input (comparator
// outputs and similar). Output lags the input by two clk edges.
//   clk   : destination clock
//   reset : asynchronous, active-high; clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output
// ---------------------------------------------------------------------------
module cp_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : cp_sync2

// File: rtl/cp_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// cp_pulse_sequencer
// Command-driven sequencer for the charge-pump switches. A burst command is
// accepted through a valid/ready handshake; the sequencer optionally
// precharges, holds all switches off for a dead time, then emits cmd_count
// source or sink pulses. A synchronized comparator stop ends the burst at
// the next pulse boundary.
//   clk, reset        : clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake (ready only in IDLE)
//   cmd_dir           : 0 = sink (snk), 1 = source (src_n)
//   cmd_count         : number of pulses requested
//   cmd_precharge     : run the precharge phase first
//   cmp_stop          : asynchronous comparator stop request
//   src_n, snk        : switch enables (src_n active-low)
//   pre_chrg          : precharge switch enable
//   busy              : burst in progress
//   done / aborted    : one-cycle completion pulse / stop-caused qualifier
//   pulses_done       : pulses emitted in the last burst
// ---------------------------------------------------------------------------
module cp_pulse_sequencer
    import cp_pkg::*;
#(
    parameter int CNT_W            = 6,
    parameter int PRECHARGE_CYCLES = 12,
    parameter int DEAD_CYCLES      = 2,
    parameter int PULSE_HI         = 1,
    parameter int PULSE_LO         = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_precharge,
    input  logic             cmp_stop,
    output logic             src_n,
    output logic             snk,
    output logic             pre_chrg,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulses_done
);

    // Phase counter counts down from (length - 1); a phase ends when it reads 0.
    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRECHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HI_LOAD   = CNT_W'(PULSE_HI - 1);
    localparam logic [CNT_W-1:0] LO_LOAD   = CNT_W'(PULSE_LO - 1);

    cp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             src_n_q, src_n_d;
    logic             snk_q, snk_d;
    logic             pre_chrg_q, pre_chrg_d;
    logic             busy_q, busy_d;

    logic             stop_sync;
    logic [CNT_W-1:0] pulses_inc;

    cp_sync2 u_stop_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (cmp_stop),
        .q_o   (stop_sync)
    );

    assign pulses_inc = pulses_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        count_d   = count_q;
        pulses_d  = pulses_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        unique case (state_q)
            CP_IDLE: begin
                if (cmd_valid) begin
                    dir_d    = cmd_dir;
                    count_d  = cmd_count;
                    pulses_d = '0;
                    if (cmd_precharge) begin
                        state_d = CP_PRECHARGE;
                        cnt_d   = PRE_LOAD;
                    end else if (cmd_count != '0) begin
                        state_d = CP_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end else begin
                        // Empty burst: complete immediately, no switching.
                        done_d = 1'b1;
                    end
                end
            end
            CP_PRECHARGE: begin
                if (cnt_q == '0) begin
                    if (count_q == '0) begin
                        state_d = CP_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CP_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CP_DEAD: begin
                if (cnt_q == '0) begin
                    state_d = CP_PULSE_HI;
                    cnt_d   = HI_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CP_PULSE_HI: begin
                if (cnt_q == '0) begin
                    state_d = CP_PULSE_LO;
                    cnt_d   = LO_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CP_PULSE_LO: begin
                if (cnt_q == '0) begin
                    pulses_d = pulses_inc;
                    // Stop is only honoured here, so a pulse is never cut short.
                    if ((pulses_inc == count_q) || stop_sync) begin
                        state_d   = CP_IDLE;
                        done_d    = 1'b1;
                        aborted_d = (pulses_inc != count_q);
                    end else begin
                        state_d = CP_PULSE_HI;
                        cnt_d   = HI_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = CP_IDLE;
            end
        endcase
    end

    // Switch enables decode the next state so they move on the same edge.
    always_comb begin
        src_n_d    = SRC_N_OFF;
        snk_d      = SNK_OFF;
        pre_chrg_d = 1'b0;
        busy_d     = (state_d != CP_IDLE);
        if (state_d == CP_PULSE_HI) begin
            if (dir_d == CP_DIR_SRC) begin
                src_n_d = ~SRC_N_OFF;
            end else begin
                snk_d = ~SNK_OFF;
            end
        end
        if (state_d == CP_PRECHARGE) begin
            pre_chrg_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CP_IDLE;
            cnt_q      <= '0;
            dir_q      <= CP_DIR_SNK;
            count_q    <= '0;
            pulses_q   <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            src_n_q    <= SRC_N_OFF;
            snk_q      <= SNK_OFF;
            pre_chrg_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            count_q    <= count_d;
            pulses_q   <= pulses_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            src_n_q    <= src_n_d;
            snk_q      <= snk_d;
            pre_chrg_q <= pre_chrg_d;
            busy_q     <= busy_d;
        end
    end

    assign cmd_ready   = (state_q == CP_IDLE);
    assign src_n       = src_n_q;
    assign snk         = snk_q;
    assign pre_chrg    = pre_chrg_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign pulses_done = pulses_q;

endmodule : cp_pulse_sequencer

// File: tb/tb_cp_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cp_pulse_sequencer
// Self-checking bench: command table plus scoreboard queue of expected
// burst results, per-cycle switch waveform model, hand-written abort,
// back-to-back and mid-burst reset sequences, and a switch-overlap monitor.
// ---------------------------------------------------------------------------
module tb_cp_pulse_sequencer;

    localparam int CW = 6;
    localparam int P  = 12;
    localparam int D  = 2;
    localparam int H  = 1;
    localparam int L  = 1;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CW-1:0] cmd_count;
    logic          cmd_precharge;
    logic          cmp_stop;
    logic          src_n;
    logic          snk;
    logic          pre_chrg;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] pulses_done;

    int errors = 0;
    int checks = 0;

    cp_pulse_sequencer #(
        .CNT_W            (CW),
        .PRECHARGE_CYCLES (P),
        .DEAD_CYCLES      (D),
        .PULSE_HI         (H),
        .PULSE_LO         (L)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dir       (cmd_dir),
        .cmd_count     (cmd_count),
        .cmd_precharge (cmd_precharge),
        .cmp_stop      (cmp_stop),
        .src_n         (src_n),
        .snk           (snk),
        .pre_chrg      (pre_chrg),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .pulses_done   (pulses_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          dir;
        logic [CW-1:0] count;
        logic          pre;
        int            min_p;
        int            max_p;
        logic          ab;
        bit            wave;
        int            done_k;   // 0 = completion cycle not checked
    } exp_t;

    typedef struct {
        logic          dir;
        logic [CW-1:0] count;
        logic          pre;
        int            exp_p;
        int            done_k;
    } vec_t;

    exp_t sb[$];
    vec_t vec[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {src_n, snk, pre_chrg, busy} in cycle k after the accept edge.
    function automatic logic [3:0] model(input exp_t e, input int k);
        int  t0;
        int  last;
        int  o;
        logic on;
        t0   = e.pre ? P : 0;
        last = t0 + ((e.count != 0) ? (D + int'(e.count) * (H + L)) : 0);
        if (k > last) return 4'b1000;
        if (k <= t0) return 4'b1011;
        if (k <= t0 + D) return 4'b1001;
        o  = k - t0 - D - 1;
        on = ((o % (H + L)) < H);
        return {~(on & e.dir), on & ~e.dir, 1'b0, 1'b1};
    endfunction

    task automatic issue(input logic dir, input logic [CW-1:0] count, input logic pre,
                         input int min_p, input int max_p, input logic ab,
                         input bit wave, input int done_k);
        exp_t e;
        cmd_dir       = dir;
        cmd_count     = count;
        cmd_precharge = pre;
        cmd_valid     = 1'b1;
        e.dir = dir; e.count = count; e.pre = pre; e.min_p = min_p; e.max_p = max_p;
        e.ab = ab; e.wave = wave; e.done_k = done_k;
        sb.push_back(e);
    endtask

    task automatic accept_edge();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Watch the current burst from cycle 1 (already sampled time) until done.
    task automatic monitor_burst();
        exp_t e;
        bit   seen;
        seen = 0;
        e = sb.pop_front();
        for (int k = 1; k <= 400 && !seen; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (e.wave) begin
                chk("wave", int'({src_n, snk, pre_chrg, busy}), int'(model(e, k)));
                if (k == 1) chk("pd_clear", int'(pulses_done), 0);
            end
            if (done) begin
                seen = 1;
                checks++;
                if (int'(pulses_done) < e.min_p || int'(pulses_done) > e.max_p) begin
                    errors++;
                    $display("FAIL pulses_range: got %0d required %0d..%0d", pulses_done, e.min_p, e.max_p);
                end
                chk("aborted", int'(aborted), int'(e.ab));
                chk("ready_at_done", int'(cmd_ready), 1);
                if (e.done_k != 0) chk("done_cycle", k, e.done_k);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, required done within 400 cycles");
        end
        $display("burst dir=%0d count=%0d pre=%0d -> pulses_done=%0d aborted=%0d",
                 e.dir, e.count, e.pre, pulses_done, aborted);
    endtask

    // Switch overlap monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((snk && !src_n) || (pre_chrg && (snk || !src_n))) begin
                errors++;
                $display("FAIL overlap: got src_n=%0d snk=%0d pre_chrg=%0d", src_n, snk, pre_chrg);
            end
        end
    end

    initial begin
        bit            saw_done;
        logic          rd;
        logic [CW-1:0] rc;
        logic          rp;
        int            dk;

        vec[0] = '{1'b0, 6'd3, 1'b0, 3, 9};
        vec[1] = '{1'b1, 6'd2, 1'b1, 2, 19};
        vec[2] = '{1'b0, 6'd0, 1'b0, 0, 1};
        vec[3] = '{1'b1, 6'd1, 1'b0, 1, 5};
        vec[4] = '{1'b0, 6'd0, 1'b1, 0, 13};
        vec[5] = '{1'b1, 6'd5, 1'b0, 5, 13};
        vec[6] = '{1'b0, 6'd4, 1'b1, 4, 23};

        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_dir       = 1'b0;
        cmd_count     = '0;
        cmd_precharge = 1'b0;
        cmp_stop      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", int'({src_n, snk, pre_chrg, busy, done, aborted}), 6'b100000);
        chk("rst_pd", int'(pulses_done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("idle_outputs", int'({src_n, snk, pre_chrg, busy, done}), 5'b10000);

        // Table-driven bursts.
        for (int i = 0; i < 7; i++) begin
            chk("ready_before", int'(cmd_ready), 1);
            issue(vec[i].dir, vec[i].count, vec[i].pre, vec[i].exp_p, vec[i].exp_p,
                  1'b0, 1, vec[i].done_k);
            accept_edge();
            monitor_burst();
            @(posedge clk);
            #1;
            chk("done_one_cycle", int'(done), 0);
            chk("pd_held", int'(pulses_done), vec[i].exp_p);
        end

        // Abort: stop raised during pulse 2 of a 10-pulse sink burst.
        issue(1'b0, 6'd10, 1'b0, 3, 4, 1'b1, 0, 0);
        accept_edge();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("abort_in_pulse2", int'(snk), 1);
        cmp_stop = 1'b1;
        monitor_burst();
        cmp_stop = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Stop held while a 1-pulse burst finishes normally: not aborted.
        cmp_stop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(1'b1, 6'd1, 1'b0, 1, 1, 1'b0, 1, 5);
        accept_edge();
        monitor_burst();
        cmp_stop = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back: next command held valid through the first burst.
        issue(1'b0, 6'd2, 1'b0, 2, 2, 1'b0, 1, 7);
        accept_edge();
        issue(1'b1, 6'd1, 1'b0, 1, 1, 1'b0, 1, 5);
        chk("ready_busy", int'(cmd_ready), 0);
        monitor_burst();
        accept_edge();
        monitor_burst();
        @(posedge clk);
        #1;

        // Reset in cycle 5 of an 8-pulse sink burst.
        cmd_dir = 1'b0; cmd_count = 6'd8; cmd_precharge = 1'b0; cmd_valid = 1'b1;
        accept_edge();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_snk", int'(snk), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_sw", int'({src_n, snk, pre_chrg, busy}), 4'b1000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", int'(cmd_ready), 1);
        saw_done = 0;
        repeat (20) begin
            if (done) saw_done = 1;
            @(posedge clk);
            #1;
        end
        chk("no_done_after_rst", int'(saw_done), 0);

        // Random commands, full waveform model, overlap monitor running.
        for (int r = 0; r < 6; r++) begin
            rd = 1'($urandom_range(0, 1));
            rc = CW'($urandom_range(0, 6));
            rp = 1'($urandom_range(0, 1));
            dk = (rp ? P : 0) + ((rc != 0) ? (D + int'(rc) * (H + L)) : 0) + 1;
            issue(rd, rc, rp, int'(rc), int'(rc), 1'b0, 1, dk);
            accept_edge();
            monitor_burst();
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cp_pulse_sequencer

// File: doc/cp_pulse_sequencer.md
Name: cp_pulse_sequencer

Overview:
Command-driven sequencer for the charge-pump switches (src_n, snk, pre_chrg).
- Accepts a burst command through a valid/ready handshake.
- Optionally precharges, inserts a break-before-make dead time, then emits N source or sink pulses of programmable width.
- Aborts early when the synchronized comparator stop input asserts.
- Sits between the digital loop/test controller and the analog charge-pump switch drivers.

Parameters:
CNT_W, 6, width of pulse count and counters
PRECHARGE_CYCLES, 12, cycles pre_chrg is held high (1..2^CNT_W-1)
DEAD_CYCLES, 2, all-switches-off cycles before the first pulse (>=1)
PULSE_HI, 1, cycles a switch is on per pulse (>=1)
PULSE_LO, 1, cycles a switch is off between pulses (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_dir  input  1  0 = sink (snk), 1 = source (src_n)
cmd_count  input  CNT_W  number of pulses requested
cmd_precharge  input  1  run the precharge phase before pulsing
cmp_stop  input  1  asynchronous comparator stop request
src_n  output  1  source switch enable, active-low
snk  output  1  sink switch enable, active-high
pre_chrg  output  1  precharge switch enable
busy  output  1  a burst is in progress
done  output  1  one-cycle pulse at burst completion
aborted  output  1  qualifies done: burst ended by cmp_stop
pulses_done  output  CNT_W  pulses emitted in the last burst; held until the next accept

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE.
  - src_n = 1, snk = 0, pre_chrg = 0.
  - busy = 0, done = 0, aborted = 0, pulses_done = 0.
  - Stop synchronizer flops cleared.
- All outputs are registered. Switch outputs are driven from next-state decode, so they change on the same edge as the state.
- cmd_ready = (state == IDLE). Accept on a clk edge with cmd_valid && cmd_ready. Command fields are latched at the accept edge.
- States: IDLE, PRECHARGE, DEAD, PULSE_HI, PULSE_LO.
- Transitions:
  - IDLE -> PRECHARGE on accept with cmd_precharge = 1.
  - IDLE -> DEAD on accept with cmd_precharge = 0 and cmd_count != 0.
  - IDLE, accept with cmd_count = 0: stays IDLE, no switch activity, done = 1 on the next cycle, pulses_done = 0.
  - PRECHARGE: pre_chrg = 1 for exactly PRECHARGE_CYCLES cycles, then -> DEAD.
    - If cmd_count = 0, -> IDLE with done instead.
  - DEAD: all switches off for DEAD_CYCLES cycles, then -> PULSE_HI.
  - PULSE_HI: PULSE_HI cycles.
    - dir = 0: snk = 1.
    - dir = 1: src_n = 0.
  - PULSE_LO: PULSE_LO cycles, switches off. At the end pulses_done increments.
    - If pulses_done == cmd_count, or sync_stop == 1: -> IDLE.
    - Otherwise -> PULSE_HI.
- Completion: in the first IDLE cycle after the burst, done = 1 for one cycle and busy = 0. aborted = 1 only if the stop caused the exit and pulses < count; otherwise 0.
- cmp_stop:
  - Passes through a 2-flop synchronizer.
  - Sampled only at the end of PULSE_LO, so a pulse is never truncated.
  - Ignored in PRECHARGE and DEAD.
  - Stop and final pulse on the same cycle: done with aborted = 0.
- Invariants:
  - snk = 1 and src_n = 0 are never asserted together.
  - pre_chrg is never asserted together with either switch.
  - A switch never turns on without at least DEAD_CYCLES off cycles after IDLE or PRECHARGE.
- busy = 1 in every non-IDLE state.
- A new command may be accepted in the same cycle that done is high.
- pulses_done is cleared to 0 at accept.
- Reset mid-burst: all switches drop off immediately (async), no done pulse.
- Counters:
  - Phase counter is CNT_W bits, saturating-free. It is reloaded at each phase entry.
  - Compares use ==. Wrap-around is impossible by the parameter limits.

Decomposition:
- Shared package cp_pkg:
  - state typedef cp_state_t.
  - Direction constants CP_DIR_SNK = 0, CP_DIR_SRC = 1.
  - Switch idle constants (SRC_N_OFF = 1, SNK_OFF = 0).
- One sub-module cp_sync2: 2-flop synchronizer with async reset. It is reused for other comparator inputs.

Test Plan:
- Sink burst, count = 3, no precharge, defaults:
  - Accept at edge 0.
  - Cycles 1-2: all off.
  - snk pattern 1,0,1,0,1,0 over cycles 3-8.
  - done = 1 at cycle 9 with aborted = 0, pulses_done = 3.
  - src_n stays 1 throughout.
- Source burst, count = 2, with precharge:
  - pre_chrg high cycles 1-12.
  - Off cycles 13-14.
  - src_n low at cycles 15 and 17.
  - done at cycle 19, pulses_done = 2.
- Abort: count = 10, cmp_stop raised permanently during pulse 2 -> burst ends after pulse 3 or 4 (sync latency), done = 1, aborted = 1, pulses_done < 10.
- Edge cases:
  - cmd_count = 0, no precharge -> no switch activity, done the cycle after accept.
  - Back-to-back command held valid during done -> accepted that cycle, pulses_done cleared.
- Reset at cycle 5 of an 8-pulse burst:
  - snk = 0, src_n = 1, busy = 0 asynchronously.
  - No done pulse.
  - cmd_ready = 1 after deassert.
- Assertion monitor over random commands: never (snk && !src_n), never (pre_chrg && (snk || !src_n)).
